// File: rtl/bin_erosion_linebuf_ctrl.sv
// Line-buffer sequencer for a 3x3 binary erosion kernel: cascades two 1-bit
// line-delay FIFOs and emits a vertically aligned 3-row column per input pixel.
module bin_erosion_linebuf_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int X_W        = 11,
    parameter int Y_W        = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_start,
    input  logic           in_vld,
    input  logic           in_pix,
    output logic           f0_wr_en,
    output logic           f0_wr_data,
    output logic           f0_rd_en,
    input  logic           f0_rd_data,
    input  logic           f0_empty,
    output logic           f1_wr_en,
    output logic           f1_wr_data,
    output logic           f1_rd_en,
    input  logic           f1_rd_data,
    input  logic           f1_empty,
    output logic           out_vld,
    output logic [2:0]     out_col,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           busy,
    output logic           err_underflow,
    output logic           err_drop
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LINE0 = 3'd1;
    localparam logic [2:0] ST_LINE1 = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    logic [2:0]     state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           pend_start_q, pend_start_d;
    logic           go_drain_q, go_drain_d;
    logic           wr_pend_q, wr_pend_d;
    logic           rd0_ok_q, rd0_ok_d;
    logic           rd1_ok_q, rd1_ok_d;
    logic           pix_d1_q, pix_d1_d;
    logic           out_vld_q, out_vld_d;
    logic [X_W-1:0] out_x_q, out_x_d;
    logic [Y_W-1:0] out_y_q, out_y_d;
    logic           err_underflow_q, err_underflow_d;
    logic           err_drop_q, err_drop_d;
    logic           line_end;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        pend_start_d    = pend_start_q;
        go_drain_d      = 1'b0;
        wr_pend_d       = 1'b0;
        rd0_ok_d        = 1'b0;
        rd1_ok_d        = 1'b0;
        pix_d1_d        = pix_d1_q;
        out_vld_d       = 1'b0;
        out_x_d         = out_x_q;
        out_y_d         = out_y_q;
        err_underflow_d = err_underflow_q;
        err_drop_d      = err_drop_q;
        f0_wr_en        = 1'b0;
        f0_rd_en        = 1'b0;
        f1_rd_en        = 1'b0;
        line_end        = (x_q == X_LAST);

        case (state_q)
            ST_IDLE: begin
                if (in_vld) err_drop_d = 1'b1;
                if (frame_start) begin
                    state_d = ST_LINE0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            ST_LINE0, ST_LINE1, ST_RUN: begin
                if (go_drain_q) begin
                    // Last pixel's cascade write lands this cycle; drain next.
                    state_d = ST_DRAIN;
                    if (frame_start) pend_start_d = 1'b1;
                end else if (frame_start) begin
                    state_d      = ST_DRAIN;
                    pend_start_d = 1'b1;
                end else if (in_vld) begin
                    f0_wr_en = 1'b1;
                    x_d      = line_end ? '0 : x_q + 1'b1;
                    if (line_end) y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;

                    if (state_q != ST_LINE0) begin
                        wr_pend_d = 1'b1;
                        if (f0_empty) begin
                            err_underflow_d = 1'b1;
                        end else begin
                            f0_rd_en = 1'b1;
                            rd0_ok_d = 1'b1;
                        end
                    end

                    if (state_q == ST_RUN) begin
                        out_vld_d = 1'b1;
                        out_x_d   = x_q;
                        out_y_d   = y_q;
                        pix_d1_d  = in_pix;
                        if (f1_empty) begin
                            err_underflow_d = 1'b1;
                        end else begin
                            f1_rd_en = 1'b1;
                            rd1_ok_d = 1'b1;
                        end
                        if (line_end && y_q == Y_LAST) go_drain_d = 1'b1;
                    end

                    if (line_end && state_q == ST_LINE0) state_d = ST_LINE1;
                    if (line_end && state_q == ST_LINE1) state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (in_vld)      err_drop_d   = 1'b1;
                if (frame_start) pend_start_d = 1'b1;
                f0_rd_en = !f0_empty;
                f1_rd_en = !f1_empty;
                // Both empty means no read is issued this cycle either.
                if (f0_empty && f1_empty) begin
                    if (pend_start_q || frame_start) begin
                        state_d      = ST_LINE0;
                        pend_start_d = 1'b0;
                        x_d          = '0;
                        y_d          = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            x_q             <= '0;
            y_q             <= '0;
            pend_start_q    <= 1'b0;
            go_drain_q      <= 1'b0;
            wr_pend_q       <= 1'b0;
            rd0_ok_q        <= 1'b0;
            rd1_ok_q        <= 1'b0;
            pix_d1_q        <= 1'b0;
            out_vld_q       <= 1'b0;
            out_x_q         <= '0;
            out_y_q         <= '0;
            err_underflow_q <= 1'b0;
            err_drop_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            pend_start_q    <= pend_start_d;
            go_drain_q      <= go_drain_d;
            wr_pend_q       <= wr_pend_d;
            rd0_ok_q        <= rd0_ok_d;
            rd1_ok_q        <= rd1_ok_d;
            pix_d1_q        <= pix_d1_d;
            out_vld_q       <= out_vld_d;
            out_x_q         <= out_x_d;
            out_y_q         <= out_y_d;
            err_underflow_q <= err_underflow_d;
            err_drop_q      <= err_drop_d;
        end
    end

    // A suppressed (underflowing) read contributes 0 for its row.
    assign f0_wr_data    = f0_wr_en & in_pix;
    assign f1_wr_en      = wr_pend_q;
    assign f1_wr_data    = wr_pend_q & rd0_ok_q & f0_rd_data;
    assign out_vld       = out_vld_q;
    assign out_col       = {out_vld_q & rd1_ok_q & f1_rd_data,
                            out_vld_q & rd0_ok_q & f0_rd_data,
                            out_vld_q & pix_d1_q};
    assign out_x         = out_x_q;
    assign out_y         = out_y_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_underflow = err_underflow_q;
    assign err_drop      = err_drop_q;

endmodule

// File: tb/tb_bin_erosion_linebuf_ctrl.sv
// Bench for bin_erosion_linebuf_ctrl on a 4x4 frame: queue-based FIFO models,
// raster-order golden columns from a stored image, directed and random frames.
module tb_bin_erosion_linebuf_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int EW  = Y_W + X_W + 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           frame_start = 1'b0;
    logic           in_vld = 1'b0;
    logic           in_pix = 1'b0;
    logic           f0_wr_en, f0_wr_data, f0_rd_en;
    logic           f1_wr_en, f1_wr_data, f1_rd_en;
    logic           f0_rd_data = 1'b0;
    logic           f1_rd_data = 1'b0;
    logic           f0_empty_m = 1'b1;
    logic           f1_empty_m = 1'b1;
    logic           force_f0 = 1'b0;
    logic           f0_empty, f1_empty;
    logic           out_vld;
    logic [2:0]     out_col;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic           busy, err_underflow, err_drop;

    int n_checks = 0;
    int n_pass   = 0;
    int out_cnt  = 0;

    logic          img [H][W];
    logic [EW-1:0] exp_q [$];
    bit            q0 [$];
    bit            q1 [$];

    always #5 clk = ~clk;

    assign f0_empty = f0_empty_m | force_f0;
    assign f1_empty = f1_empty_m;

    bin_erosion_linebuf_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .in_vld       (in_vld),
        .in_pix       (in_pix),
        .f0_wr_en     (f0_wr_en),
        .f0_wr_data   (f0_wr_data),
        .f0_rd_en     (f0_rd_en),
        .f0_rd_data   (f0_rd_data),
        .f0_empty     (f0_empty),
        .f1_wr_en     (f1_wr_en),
        .f1_wr_data   (f1_wr_data),
        .f1_rd_en     (f1_rd_en),
        .f1_rd_data   (f1_rd_data),
        .f1_empty     (f1_empty),
        .out_vld      (out_vld),
        .out_col      (out_col),
        .out_x        (out_x),
        .out_y        (out_y),
        .busy         (busy),
        .err_underflow(err_underflow),
        .err_drop     (err_drop)
    );

    // Behavioural 1-bit FIFOs: read data one cycle after rd_en, reset with rst.
    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            f0_rd_data <= 1'b0;
            f1_rd_data <= 1'b0;
            f0_empty_m <= 1'b1;
            f1_empty_m <= 1'b1;
        end else begin
            if (f0_rd_en && q0.size() != 0) f0_rd_data <= q0.pop_front();
            if (f1_rd_en && q1.size() != 0) f1_rd_data <= q1.pop_front();
            if (f0_wr_en) q0.push_back(f0_wr_data);
            if (f1_wr_en) q1.push_back(f1_wr_data);
            f0_empty_m <= (q0.size() == 0);
            f1_empty_m <= (q1.size() == 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_vld) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_vld), 64'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("out_col_xy", 64'({out_y, out_x, out_col}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] all_outs();
        return 64'({f0_wr_en, f0_wr_data, f0_rd_en, f1_wr_en, f1_wr_data, f1_rd_en,
                    out_vld, out_col, out_x, out_y, busy, err_underflow, err_drop});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int y, input logic [3:0] bits);
        for (int x = 0; x < W; x++) img[y][x] = bits[3-x];
    endtask

    task automatic rand_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = 1'($urandom_range(0, 1));
    endtask

    // Column {row y-2, row y-1, row y} at (x, y); mid_ok=0 models a lost middle row.
    task automatic push_expect(input int y, input int x, input logic mid_ok);
        exp_q.push_back({Y_W'(y), X_W'(x), img[y-2][x], img[y-1][x] & mid_ok, img[y][x]});
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // gap_kind: 0 = back-to-back, 1 = one idle cycle per pixel, 2 = random 0..2.
    task automatic send_pixels(input int gap_kind, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            int y = i / W;
            int x = i % W;
            int g = (gap_kind == 1) ? 1 : (gap_kind == 2) ? int'($urandom_range(0, 2)) : 0;
            in_vld = 1'b0;
            repeat (g) tick();
            if (y >= 2) push_expect(y, x, 1'b1);
            in_vld = 1'b1;
            in_pix = img[y][x];
            tick();
        end
        in_vld = 1'b0;
        in_pix = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!(f0_empty_m && f1_empty_m) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(f0_empty_m & f1_empty_m), 64'd1);
    endtask

    task automatic set_golden();
        set_row(0, 4'b1111);
        set_row(1, 4'b1011);
        set_row(2, 4'b1111);
        set_row(3, 4'b0110);
    endtask

    initial begin
        int n;

        tick();
        check("reset_outs_in_rst", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("reset_outs_idle", all_outs(), 64'd0);

        // Test 1: golden frame, continuous input.
        set_golden();
        out_cnt = 0;
        start_frame();
        send_pixels(0, W * H);
        wait_idle(n);
        check("t1_busy_drop_le6", 64'(n <= 6), 64'd1);
        check("t1_out_count", 64'(out_cnt), 64'd8);
        check("t1_exp_left", 64'(exp_q.size()), 64'd0);

        // Test 2: same frame with an idle cycle before every pixel.
        out_cnt = 0;
        start_frame();
        send_pixels(1, W * H);
        wait_idle(n);
        check("t2_out_count", 64'(out_cnt), 64'd8);

        // Test 3: second frame_start lands during DRAIN.
        out_cnt = 0;
        start_frame();
        send_pixels(0, W * H);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_empty("t3_drain_empty");
        tick();
        check("t3_busy_line0", 64'(busy), 64'd1);
        send_pixels(0, W * H);
        wait_idle(n);
        check("t3_out_count", 64'(out_cnt), 64'd16);
        check("t3_err_flags", 64'({err_underflow, err_drop}), 64'd0);

        // Test 4: abort at row 2, x=1, then a fresh frame from pend_start.
        rand_img();
        out_cnt = 0;
        start_frame();
        send_pixels(0, 2 * W + 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_empty("t4_drain_empty");
        tick();
        rand_img();
        send_pixels(0, W * H);
        wait_idle(n);
        check("t4_out_count", 64'(out_cnt), 64'd9);
        check("t4_exp_left", 64'(exp_q.size()), 64'd0);

        // Random frames with random gaps.
        for (int f = 0; f < 6; f++) begin
            rand_img();
            out_cnt = 0;
            repeat ($urandom_range(0, 3)) tick();
            start_frame();
            send_pixels(2, W * H);
            wait_idle(n);
            check("rand_out_count", 64'(out_cnt), 64'd8);
        end
        check("rand_err_flags", 64'({err_underflow, err_drop}), 64'd0);

        // Test 5: drop in IDLE is sticky; forced f0 empty in RUN underflows.
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("t5_err_drop", 64'(err_drop), 64'd1);
        repeat (3) tick();
        check("t5_err_drop_sticky", 64'(err_drop), 64'd1);
        rand_img();
        start_frame();
        send_pixels(0, 2 * W);
        push_expect(2, 0, 1'b0);
        force_f0 = 1'b1;
        in_vld   = 1'b1;
        in_pix   = img[2][0];
        tick();
        force_f0 = 1'b0;
        in_vld   = 1'b0;
        tick();
        check("t5_err_underflow", 64'(err_underflow), 64'd1);
        check("t5_err_drop_held", 64'(err_drop), 64'd1);
        check("t5_exp_left", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_clears", all_outs(), 64'd0);

        // Test 6: reset mid-frame at row 1, x=2, then a clean frame.
        rand_img();
        start_frame();
        send_pixels(0, W + 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_outs_after_rst", all_outs(), 64'd0);
        tick();
        rand_img();
        out_cnt = 0;
        start_frame();
        send_pixels(0, W * H);
        wait_idle(n);
        check("t6_out_count", 64'(out_cnt), 64'd8);
        check("t6_exp_left", 64'(exp_q.size()), 64'd0);
        check("t6_err_flags", 64'({err_underflow, err_drop}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_erosion_linebuf_ctrl.md
Name: bin_erosion_linebuf_ctrl

Overview:
- Sequences the two single-clock 1-bit line-delay FIFOs (u_fifo_bin_erosion instances, SYN, c_OUTPUT_REG=0, depth ≥ IMG_WIDTH) that feed the 3x3 binary erosion kernel.
- Writes incoming pixels into FIFO0, cascades FIFO0 output into FIFO1, and emits an aligned 3-row column (rows y-2, y-1, y) per input pixel.
- Drains both FIFOs at end of frame or on abort, so every frame starts with both FIFOs empty.

Parameters:
IMG_WIDTH, 640, active pixels per line; must be ≤ FIFO depth (1024)
IMG_HEIGHT, 480, active lines per frame; must be ≥ 3
X_W, 11, column counter width
Y_W, 10, row counter width

Ports:
clk  input  1  single system clock; FIFO wr_clk and rd_clk tie to it
rst  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse before the first pixel of a frame
in_vld  input  1  input pixel valid
in_pix  input  1  binary input pixel
f0_wr_en  output  1  FIFO0 write enable
f0_wr_data  output  1  FIFO0 write data (= in_pix)
f0_rd_en  output  1  FIFO0 read enable
f0_rd_data  input  1  FIFO0 read data, valid 1 cycle after f0_rd_en
f0_empty  input  1  FIFO0 rd_empty
f1_wr_en  output  1  FIFO1 write enable
f1_wr_data  output  1  FIFO1 write data (= f0_rd_data)
f1_rd_en  output  1  FIFO1 read enable
f1_rd_data  input  1  FIFO1 read data, valid 1 cycle after f1_rd_en
f1_empty  input  1  FIFO1 rd_empty
out_vld  output  1  out_col valid
out_col  output  3  {row y-2, row y-1, row y} at column out_x
out_x  output  X_W  column of out_col
out_y  output  Y_W  row index y of the bottom pixel
busy  output  1  high in any state except IDLE
err_underflow  output  1  sticky: a read was required while the FIFO was empty
err_drop  output  1  sticky: in_vld was seen in IDLE or DRAIN

Behaviour:
- Reset: state=IDLE. All outputs are 0, including both sticky error flags. Counters x=0, y=0. pend_start=0.
- Counters:
  - x increments on each accepted in_vld and wraps IMG_WIDTH-1→0.
  - On that wrap, y increments.
- IDLE:
  - frame_start → LINE0 with x=y=0.
  - in_vld is ignored and sets err_drop.
- LINE0 (y=0):
  - in_vld → f0_wr_en=1 in the same cycle. No reads.
  - After pixel IMG_WIDTH-1 → LINE1.
- LINE1 (y=1):
  - in_vld → f0_rd_en=1 and f0_wr_en=1 in the same cycle (FIFO0 occupancy stays at W).
  - Next cycle: f1_wr_en=1 with f1_wr_data=f0_rd_data. out_vld stays 0.
  - Line end → RUN.
- RUN (2 ≤ y ≤ IMG_HEIGHT-1):
  - in_vld at cycle t → f0_rd_en=f1_rd_en=f0_wr_en=1 at t.
  - At t+1: f1_wr_en=1 (f1_wr_data=f0_rd_data), out_vld=1, out_col={f1_rd_data, f0_rd_data, pix_d1}.
  - out_x and out_y are the values registered at t. Latency from in_vld to out_vld is 1 cycle.
  - After pixel (IMG_WIDTH-1, IMG_HEIGHT-1): the last t+1 write completes, then → DRAIN.
- DRAIN:
  - Each cycle, assert f0_rd_en while !f0_empty and f1_rd_en while !f1_empty. No writes.
  - When both FIFOs are empty and no read is in flight → IDLE.
  - If pend_start=1 at that point → LINE0 directly and pend_start clears.
  - Drain completes in ≤ IMG_WIDTH+2 cycles.
- frame_start during LINE0/LINE1/RUN is an abort:
  - Finish any pending t+1 write, then → DRAIN and set pend_start.
  - The partial frame is discarded and out_vld stays 0 thereafter.
- frame_start during DRAIN sets pend_start.
- Underflow: any required rd_en while the corresponding empty=1 sets err_underflow. The rd_en is still suppressed for that FIFO and out_col takes 0 for that row.
- in_vld in DRAIN is dropped and sets err_drop.
- Back-to-back in_vld is supported at full rate (1 pixel/clk). Gaps in in_vld are allowed; nothing advances without in_vld except DRAIN.
- rst asserted mid-frame returns to the reset state on the next edge. FIFO contents are not cleared by this block: the integrator drives FIFO wr_rst/rd_rst from the same rst.

Test Plan:
1. 4x4 frame (IMG_WIDTH=4, IMG_HEIGHT=4), continuous in_vld, rows 1111/1011/1111/0110 → out_vld=1 for exactly 8 cycles (rows 2,3). First out_col=3'b111 at out_x=0, out_y=2. Column x=1 of row 2 gives 3'b101. busy drops ≤ 6 cycles after the last pixel.
2. Same frame with in_vld=0 inserted every other cycle → identical out_col sequence; out_vld count = 8.
3. Two frames back-to-back, frame_start arriving during DRAIN → second frame enters LINE0 directly after the drain. Output matches the single-frame golden; err_* remain 0.
4. Abort: frame_start at row 2, x=1 → out_vld=0 afterwards; DRAIN empties both FIFOs (f0_empty=f1_empty=1); new frame then produces a correct golden output.
5. in_vld pulsed in IDLE → err_drop=1 and stays 1 until rst. Forcing f0_empty=1 in RUN → err_underflow=1 and the out_col middle bit reads 0.
6. rst asserted at row 1, x=2 → next cycle all outputs are 0, state=IDLE; a subsequent frame produces the correct output.
